leaf_tx_packetizer: RTL and testbench
=====================================

Name: leaf_tx_packetizer

Overview:
- Leaf-side transmit stage that turns an operator's 32-bit word stream into 49-bit BFT packets on the leaf-to-network bus.
- Buffers words in a small FIFO and stamps each with a destination leaf/port and a sequence number.
- Destination is configured by a config packet arriving on the network-to-leaf bus.
- Honours the network's resend signal by holding the current output word.

Parameters:
- PAYLOAD_W, 32, operator data width.
- PKT_W, 49, BFT packet width; must equal 1+5+4+7+PAYLOAD_W.
- FIFO_DEPTH, 4, input buffer entries; must be a power of 2, at least 2.
- CFG_PORT, 4'd0, port number that marks a config packet.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- din_leaf_bft2interface  in  49  network-to-leaf packet; only config packets are used here.
- resend  in  1  network stall; hold the current output.
- stream_in_data  in  32  operator word.
- stream_in_valid  in  1  operator word valid.
- stream_in_ready  out  1  FIFO can accept a word.
- dout_leaf_interface2bft  out  49  leaf-to-network packet (registered).
- configured  out  1  destination has been loaded.

Behaviour:
- Packet format:
  - [48] valid
  - [47:43] dest_leaf
  - [42:39] dest_port
  - [38:32] seq
  - [31:0] payload
- Reset (synchronous, highest priority): dout=0, FIFO empty, seq=0, dest_leaf=0, dest_port=0, configured=0. stream_in_ready reads 0 during the reset cycle, then 1.
- Reset mid-operation discards all buffered words and any held packet.
- Config: when din[48]=1 and din[42:39]==CFG_PORT at an edge:
  - dest_leaf<=din[4:0], dest_port<=din[8:5], configured<=1.
  - Re-config is allowed at any time and takes effect from the next pop.
  - A pop in the same cycle uses the old destination.
- Non-config din packets are ignored.
- Input handshake:
  - stream_in_ready = !full, derived from registered pointers only. It does not depend on a same-cycle pop.
  - A push occurs when valid&&ready.
  - Full: ready=0; a word presented while full is not taken, and the operator holds it.
- Pointers: log2(FIFO_DEPTH)+1 bits, wrapping naturally.
  - empty when pointers are equal.
  - full when MSBs differ and the rest are equal.
- Output, each edge when not in reset:
  - resend=1: dout holds its value, no pop, seq holds. This holds regardless of empty/configured state.
  - else if !empty && configured: pop the head; dout<={1,dest_leaf,dest_port,seq,head}; seq<=seq+1 (7-bit, 127 wraps to 0).
  - else: dout<=0. The valid bit is low and the whole word is zeroed.
- Unconfigured: words accumulate up to FIFO_DEPTH, then backpressure; nothing is emitted.
- Latency: a word accepted at edge N into an empty FIFO appears on dout after edge N+1. Sustained throughput is 1 word/cycle.
- Simultaneous push and pop are legal when not full; occupancy is unchanged.
- Simultaneous resend and config: config still loads; dout holds.

Decomposition:
- Shared package bft_pkg holds:
  - PKT_W, field offsets/widths (VALID_BIT, LEAF_LSB, PORT_LSB, SEQ_LSB), CFG_PORT.
  - a packed struct bft_pkt_t {valid, leaf[4:0], port[3:0], seq[6:0], payload[31:0]}.
- One sub-module, leaf_sync_fifo: parameterised width/depth synchronous FIFO with push/pop/full/empty. The packetizer instantiates it and holds the config, seq and output registers.

Test Plan:
- Reset then 3 words (0xA, 0xB, 0xC) with no config -> dout stays 0, configured=0, ready stays 1, FIFO holds 3.
- Config din={1,5'd0,4'd0,7'd0,23'd0,dest_port=4'd3,dest_leaf=5'd9} with those 3 words buffered -> next 3 cycles dout valid, leaf=9, port=3, seq 0,1,2, payloads A,B,C; then dout=0.
- Stream 0x11..0x16 continuously and raise resend for 2 cycles at word 0x13 -> 0x13 is held on dout for 3 cycles total, seq not skipped, 0x14 follows.
- Unconfigured, push 5 words -> ready drops after the 4th, 5th not taken; config -> 4 pops, ready returns, 5th word sent with seq=4.
- 130 words after config -> seq goes 126, 127, 0, 1; no gaps or duplicates.
- Assert reset with 2 words buffered and resend high -> next cycle dout=0, empty, seq=0, configured=0.

Source files
------------

// File: rtl/bft_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bft_pkg
// Description : BFT packet geometry, field offsets and packet struct shared by
//               the leaf transmit path.
// Revision    : 1.0 - initial release
// ============================================================================
package bft_pkg;

  localparam int PAYLOAD_W = 32;
  localparam int LEAF_W    = 5;
  localparam int PORT_W    = 4;
  localparam int SEQ_W     = 7;
  localparam int PKT_W     = 1 + LEAF_W + PORT_W + SEQ_W + PAYLOAD_W;

  localparam int VALID_BIT = PKT_W - 1;
  localparam int LEAF_LSB  = VALID_BIT - LEAF_W;
  localparam int PORT_LSB  = LEAF_LSB - PORT_W;
  localparam int SEQ_LSB   = PORT_LSB - SEQ_W;

  localparam logic [PORT_W-1:0] CFG_PORT = 4'd0;

  typedef struct packed {
    logic                 valid;
    logic [LEAF_W-1:0]    leaf;
    logic [PORT_W-1:0]    port;
    logic [SEQ_W-1:0]     seq;
    logic [PAYLOAD_W-1:0] payload;
  } bft_pkt_t;

endpackage
`default_nettype wire

// File: rtl/leaf_tx_packetizer_if.sv
`default_nettype none
// ============================================================================
// Interface   : leaf_tx_packetizer_if
// Description : Operator stream, network-to-leaf and leaf-to-network buses of
//               the leaf transmit packetizer.
// Revision    : 1.0 - initial release
// ============================================================================
interface leaf_tx_packetizer_if;
  import bft_pkg::*;

  logic [PKT_W-1:0]     din_leaf_bft2interface;
  logic                 resend;
  logic [PAYLOAD_W-1:0] stream_in_data;
  logic                 stream_in_valid;
  logic                 stream_in_ready;
  logic [PKT_W-1:0]     dout_leaf_interface2bft;
  logic                 configured;

  modport slave (
    input  din_leaf_bft2interface,
    input  resend,
    input  stream_in_data,
    input  stream_in_valid,
    output stream_in_ready,
    output dout_leaf_interface2bft,
    output configured
  );

  modport master (
    output din_leaf_bft2interface,
    output resend,
    output stream_in_data,
    output stream_in_valid,
    input  stream_in_ready,
    input  dout_leaf_interface2bft,
    input  configured
  );

endinterface
`default_nettype wire

// File: rtl/leaf_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : leaf_sync_fifo
// Description : Single-clock FIFO with extra-MSB pointers for full/empty.
// Revision    : 1.0 - initial release
// ============================================================================
module leaf_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             push_i,
  input  wire logic [WIDTH-1:0] wdata_i,
  input  wire logic             pop_i,
  output logic      [WIDTH-1:0] head_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/leaf_tx_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : leaf_tx_packetizer
// Description : Buffers operator words and emits them as sequenced BFT packets
//               to a configured leaf/port, holding output on network resend.
// Revision    : 1.0 - initial release
// ============================================================================
module leaf_tx_packetizer
  import bft_pkg::*;
#(
  parameter int              PAYLOAD_W  = bft_pkg::PAYLOAD_W,
  parameter int              PKT_W      = bft_pkg::PKT_W,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [3:0]      CFG_PORT   = bft_pkg::CFG_PORT
) (
  input  wire logic          clk,
  input  wire logic          reset,
  leaf_tx_packetizer_if.slave bus
);

  logic [LEAF_W-1:0]    leaf_q, leaf_d;
  logic [PORT_W-1:0]    port_q, port_d;
  logic [SEQ_W-1:0]     seq_q, seq_d;
  logic                 configured_q, configured_d;
  logic [PKT_W-1:0]     dout_q, dout_d;
  bft_pkt_t             pkt;

  logic                 cfg_hit;
  logic                 push, pop, full, empty;
  logic [PAYLOAD_W-1:0] head;
  logic                 unused_din;

  leaf_sync_fifo #(
    .WIDTH (PAYLOAD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (bus.stream_in_data),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.stream_in_ready         = !full && !reset;
  assign push                        = bus.stream_in_valid && bus.stream_in_ready;
  assign bus.dout_leaf_interface2bft = dout_q;
  assign bus.configured              = configured_q;

  assign unused_din = ^{bus.din_leaf_bft2interface[VALID_BIT-1:PORT_LSB+PORT_W],
                        bus.din_leaf_bft2interface[PORT_LSB-1:LEAF_W+PORT_W]};

  always_comb begin
    leaf_d       = leaf_q;
    port_d       = port_q;
    configured_d = configured_q;
    seq_d        = seq_q;
    dout_d       = dout_q;
    pop          = 1'b0;
    pkt          = '0;

    cfg_hit = bus.din_leaf_bft2interface[VALID_BIT] &&
              (bus.din_leaf_bft2interface[PORT_LSB +: PORT_W] == CFG_PORT);
    if (cfg_hit) begin
      leaf_d       = bus.din_leaf_bft2interface[LEAF_W-1:0];
      port_d       = bus.din_leaf_bft2interface[LEAF_W +: PORT_W];
      configured_d = 1'b1;
    end

    // A pop in the config cycle still stamps the old destination (leaf_q/port_q).
    if (!bus.resend) begin
      if (!empty && configured_q) begin
        pop         = 1'b1;
        pkt.valid   = 1'b1;
        pkt.leaf    = leaf_q;
        pkt.port    = port_q;
        pkt.seq     = seq_q;
        pkt.payload = head;
        dout_d      = pkt;
        seq_d       = seq_q + 1'b1;
      end else begin
        dout_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      leaf_q       <= '0;
      port_q       <= '0;
      seq_q        <= '0;
      configured_q <= 1'b0;
      dout_q       <= '0;
    end else begin
      leaf_q       <= leaf_d;
      port_q       <= port_d;
      seq_q        <= seq_d;
      configured_q <= configured_d;
      dout_q       <= dout_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_leaf_tx_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_leaf_tx_packetizer
// Description : Directed self-checking bench for leaf_tx_packetizer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_leaf_tx_packetizer;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  leaf_tx_packetizer_if bus ();

  leaf_tx_packetizer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [48:0] mk(input logic [4:0] leaf, input logic [3:0] port,
                                     input logic [6:0] seq, input logic [31:0] pl);
    return {1'b1, leaf, port, seq, pl};
  endfunction

  function automatic logic [48:0] cfg_pkt(input logic [4:0] leaf, input logic [3:0] port);
    return {1'b1, 5'd0, 4'd0, 7'd0, 23'd0, port, leaf};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    tests++;
    if (bus.stream_in_ready !== 1'b0) begin
      fails++; $display("FAIL reset_ready_low: got %b expected 0", bus.stream_in_ready);
    end
    tick();
    tests++;
    if (bus.dout_leaf_interface2bft !== 49'd0 || bus.configured !== 1'b0) begin
      fails++; $display("FAIL reset_state: dout %h cfg %b expected 0/0",
                        bus.dout_leaf_interface2bft, bus.configured);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (bus.stream_in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready_high: got %b expected 1", bus.stream_in_ready);
    end
  endtask

  task automatic test_unconfigured();
    logic [31:0] words [3];
    words[0] = 32'hA; words[1] = 32'hB; words[2] = 32'hC;
    for (int i = 0; i < 3; i++) begin
      bus.stream_in_valid = 1'b1;
      bus.stream_in_data  = words[i];
      tick();
      tests++;
      if (bus.dout_leaf_interface2bft !== 49'd0 || bus.configured !== 1'b0 ||
          bus.stream_in_ready !== 1'b1) begin
        fails++; $display("FAIL uncfg_word%0d: dout %h cfg %b rdy %b expected 0/0/1", i,
                          bus.dout_leaf_interface2bft, bus.configured, bus.stream_in_ready);
      end
    end
    bus.stream_in_valid = 1'b0;
  endtask

  task automatic test_config();
    logic [31:0] words [3];
    words[0] = 32'hA; words[1] = 32'hB; words[2] = 32'hC;
    bus.din_leaf_bft2interface = cfg_pkt(5'd9, 4'd3);
    tick();
    bus.din_leaf_bft2interface = '0;
    tests++;
    if (bus.dout_leaf_interface2bft !== 49'd0 || bus.configured !== 1'b1) begin
      fails++; $display("FAIL cfg_edge: dout %h cfg %b expected 0/1",
                        bus.dout_leaf_interface2bft, bus.configured);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (bus.dout_leaf_interface2bft !== mk(5'd9, 4'd3, 7'(i), words[i])) begin
        fails++; $display("FAIL cfg_pop%0d: got %h expected %h", i,
                          bus.dout_leaf_interface2bft, mk(5'd9, 4'd3, 7'(i), words[i]));
      end
    end
    tick();
    tests++;
    if (bus.dout_leaf_interface2bft !== 49'd0) begin
      fails++; $display("FAIL cfg_drain: got %h expected 0", bus.dout_leaf_interface2bft);
    end
  endtask

  task automatic test_resend();
    // Per cycle: data driven, resend driven, expected dout after the edge.
    logic [31:0] data [10];
    logic        rs   [10];
    logic        vld  [10];
    logic [48:0] exp  [10];
    data = '{32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 0, 0, 0, 0};
    rs   = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    vld  = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    exp[0] = 49'd0;
    exp[1] = mk(5'd9, 4'd3, 7'd3, 32'h11);
    exp[2] = mk(5'd9, 4'd3, 7'd4, 32'h12);
    exp[3] = mk(5'd9, 4'd3, 7'd5, 32'h13);
    exp[4] = mk(5'd9, 4'd3, 7'd5, 32'h13);
    exp[5] = mk(5'd9, 4'd3, 7'd5, 32'h13);
    exp[6] = mk(5'd9, 4'd3, 7'd6, 32'h14);
    exp[7] = mk(5'd9, 4'd3, 7'd7, 32'h15);
    exp[8] = mk(5'd9, 4'd3, 7'd8, 32'h16);
    exp[9] = 49'd0;
    for (int i = 0; i < 10; i++) begin
      bus.stream_in_valid = vld[i];
      bus.stream_in_data  = data[i];
      bus.resend          = rs[i];
      tick();
      tests++;
      if (bus.dout_leaf_interface2bft !== exp[i]) begin
        fails++; $display("FAIL resend_cyc%0d: got %h expected %h", i,
                          bus.dout_leaf_interface2bft, exp[i]);
      end
    end
    bus.resend = 1'b0;
  endtask

  task automatic test_backpressure();
    reset = 1'b1; tick(); reset = 1'b0;
    bus.stream_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.stream_in_data = 32'h21 + 32'(i);
      tick();
    end
    tests++;
    if (bus.stream_in_ready !== 1'b0) begin
      fails++; $display("FAIL bp_full: ready %b expected 0", bus.stream_in_ready);
    end
    bus.stream_in_data = 32'h25;
    tick();
    tests++;
    if (bus.stream_in_ready !== 1'b0 || bus.dout_leaf_interface2bft !== 49'd0) begin
      fails++; $display("FAIL bp_hold: ready %b dout %h expected 0/0",
                        bus.stream_in_ready, bus.dout_leaf_interface2bft);
    end
    bus.din_leaf_bft2interface = cfg_pkt(5'd9, 4'd3);
    tick();
    bus.din_leaf_bft2interface = '0;
    tests++;
    if (bus.stream_in_ready !== 1'b0 || bus.dout_leaf_interface2bft !== 49'd0) begin
      fails++; $display("FAIL bp_cfg: ready %b dout %h expected 0/0",
                        bus.stream_in_ready, bus.dout_leaf_interface2bft);
    end
    tick();
    tests++;
    if (bus.dout_leaf_interface2bft !== mk(5'd9, 4'd3, 7'd0, 32'h21) ||
        bus.stream_in_ready !== 1'b1) begin
      fails++; $display("FAIL bp_pop0: got %h rdy %b expected %h rdy 1",
                        bus.dout_leaf_interface2bft, bus.stream_in_ready,
                        mk(5'd9, 4'd3, 7'd0, 32'h21));
    end
    tick();
    bus.stream_in_valid = 1'b0;
    tests++;
    if (bus.dout_leaf_interface2bft !== mk(5'd9, 4'd3, 7'd1, 32'h22)) begin
      fails++; $display("FAIL bp_pop1: got %h expected %h",
                        bus.dout_leaf_interface2bft, mk(5'd9, 4'd3, 7'd1, 32'h22));
    end
    for (int i = 2; i < 5; i++) begin
      tick();
      tests++;
      if (bus.dout_leaf_interface2bft !== mk(5'd9, 4'd3, 7'(i), 32'h21 + 32'(i))) begin
        fails++; $display("FAIL bp_pop%0d: got %h expected %h", i,
                          bus.dout_leaf_interface2bft, mk(5'd9, 4'd3, 7'(i), 32'h21 + 32'(i)));
      end
    end
    tick();
    tests++;
    if (bus.dout_leaf_interface2bft !== 49'd0) begin
      fails++; $display("FAIL bp_drain: got %h expected 0", bus.dout_leaf_interface2bft);
    end
  endtask

  task automatic test_seq_wrap();
    reset = 1'b1; tick(); reset = 1'b0;
    bus.din_leaf_bft2interface = cfg_pkt(5'd9, 4'd3);
    tick();
    bus.din_leaf_bft2interface = '0;
    for (int i = 0; i <= 130; i++) begin
      bus.stream_in_valid = (i < 130);
      bus.stream_in_data  = 32'd1000 + 32'(i);
      tick();
      if (i >= 1) begin
        tests++;
        if (bus.dout_leaf_interface2bft !==
            mk(5'd9, 4'd3, 7'((i - 1) % 128), 32'd1000 + 32'(i - 1))) begin
          fails++; $display("FAIL wrap_word%0d: got %h expected %h", i - 1,
                            bus.dout_leaf_interface2bft,
                            mk(5'd9, 4'd3, 7'((i - 1) % 128), 32'd1000 + 32'(i - 1)));
        end
      end
    end
    bus.stream_in_valid = 1'b0;
  endtask

  task automatic test_reconfig();
    // Seq is 2 after 130 words; non-config packet must be ignored.
    bus.din_leaf_bft2interface = {1'b1, 5'd31, 4'd6, 7'd5, 23'd0, 4'd1, 5'd17};
    bus.stream_in_valid = 1'b1;
    bus.stream_in_data  = 32'h51;
    tick();
    tests++;
    if (bus.dout_leaf_interface2bft !== 49'd0) begin
      fails++; $display("FAIL recfg_push: got %h expected 0", bus.dout_leaf_interface2bft);
    end
    bus.din_leaf_bft2interface = cfg_pkt(5'd2, 4'd7);
    bus.stream_in_data         = 32'h52;
    tick();
    bus.din_leaf_bft2interface = '0;
    bus.stream_in_valid        = 1'b0;
    tests++;
    if (bus.dout_leaf_interface2bft !== mk(5'd9, 4'd3, 7'd2, 32'h51)) begin
      fails++; $display("FAIL recfg_old_dest: got %h expected %h",
                        bus.dout_leaf_interface2bft, mk(5'd9, 4'd3, 7'd2, 32'h51));
    end
    tick();
    tests++;
    if (bus.dout_leaf_interface2bft !== mk(5'd2, 4'd7, 7'd3, 32'h52)) begin
      fails++; $display("FAIL recfg_new_dest: got %h expected %h",
                        bus.dout_leaf_interface2bft, mk(5'd2, 4'd7, 7'd3, 32'h52));
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.stream_in_valid = 1'b1;
    bus.stream_in_data  = 32'h61;
    tick();
    bus.stream_in_data  = 32'h62;
    tick();
    bus.stream_in_data  = 32'h63;
    bus.resend          = 1'b1;
    tick();
    bus.stream_in_valid = 1'b0;
    tests++;
    if (bus.dout_leaf_interface2bft !== mk(5'd2, 4'd7, 7'd4, 32'h61)) begin
      fails++; $display("FAIL mid_held: got %h expected %h",
                        bus.dout_leaf_interface2bft, mk(5'd2, 4'd7, 7'd4, 32'h61));
    end
    reset = 1'b1;
    tick();
    tests++;
    if (bus.dout_leaf_interface2bft !== 49'd0 || bus.configured !== 1'b0) begin
      fails++; $display("FAIL mid_reset: dout %h cfg %b expected 0/0",
                        bus.dout_leaf_interface2bft, bus.configured);
    end
    reset      = 1'b0;
    bus.resend = 1'b0;
    bus.din_leaf_bft2interface = cfg_pkt(5'd9, 4'd3);
    tick();
    bus.din_leaf_bft2interface = '0;
    tick();
    tests++;
    if (bus.dout_leaf_interface2bft !== 49'd0) begin
      fails++; $display("FAIL mid_empty: got %h expected 0", bus.dout_leaf_interface2bft);
    end
    bus.stream_in_valid = 1'b1;
    bus.stream_in_data  = 32'h77;
    tick();
    bus.stream_in_valid = 1'b0;
    tick();
    tests++;
    if (bus.dout_leaf_interface2bft !== mk(5'd9, 4'd3, 7'd0, 32'h77)) begin
      fails++; $display("FAIL mid_seq0: got %h expected %h",
                        bus.dout_leaf_interface2bft, mk(5'd9, 4'd3, 7'd0, 32'h77));
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    bus.din_leaf_bft2interface = '0;
    bus.resend                 = 1'b0;
    bus.stream_in_data         = '0;
    bus.stream_in_valid        = 1'b0;
    @(negedge clk);
    test_reset();
    test_unconfigured();
    test_config();
    test_resend();
    test_backpressure();
    test_seq_wrap();
    test_reconfig();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
